// File: rtl/ppbuf_ctrl.sv
// ppbuf_ctrl: sequencer for the interleaver's two-bank ping-pong bit buffer.
// The interleaver fills one bank in permuted order while the modulator drains
// the other in linear order through a 2-entry skid FIFO that sits behind the
// 1-cycle synchronous-read RAM.
// Optional build macro PPBUF_STATUS_EN adds blk_cnt (completed drains) and a
// sticky idx_err flag for out-of-range write indices, which are also kept out of the RAM.
//
// bank state | meaning
// EMPTY      | free for the writer
// FILLING    | writer has stored at least one bit of the block
// FULL       | all NCBPS bits written, no read issued yet
// DRAINING   | reads in progress, released on the NCBPS-th read issue
module ppbuf_ctrl #(
  parameter int NCBPS = 192,
  parameter int AW    = $clog2(NCBPS)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_index,
  input  logic          wr_data,
  output logic          wr_ready,
  output logic          mem_we,
  output logic          mem_wbank,
  output logic [AW-1:0] mem_waddr,
  output logic          mem_wdata,
  output logic          mem_re,
  output logic          mem_rbank,
  output logic [AW-1:0] mem_raddr,
  input  logic          mem_q,
  output logic          out_valid,
  output logic          out_data,
  input  logic          out_ready
`ifdef PPBUF_STATUS_EN
  ,
  output logic [15:0]   blk_cnt,
  output logic          idx_err
`endif
);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_t;

  localparam logic [AW-1:0] LAST = AW'(NCBPS - 1);

  bank_st_t      bank_st     [2];
  bank_st_t      bank_st_nxt [2];
  logic          wbank, rbank;
  logic [AW-1:0] wcnt, rcnt;
  logic          inflight;
  logic [1:0]    fifo_occ;
  logic          fifo_mem [2];
  logic          fifo_rp, fifo_wp;

  logic          wr_acc, wr_last, rd_last, pop;
  logic          idx_bad;
  logic [1:0]    credit;

  // Bank state register plus the bookkeeping that moves with it
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      wcnt       <= '0;
      rcnt       <= '0;
      inflight   <= 1'b0;
    end else begin
      bank_st[0] <= bank_st_nxt[0];
      bank_st[1] <= bank_st_nxt[1];
      inflight   <= mem_re;
      if (wr_acc) begin
        wcnt <= wr_last ? '0 : wcnt + 1'b1;
        if (wr_last) wbank <= ~wbank;
      end
      if (mem_re) begin
        rcnt <= rd_last ? '0 : rcnt + 1'b1;
        if (rd_last) rbank <= ~rbank;
      end
    end
  end

  // Next bank states; the writer and reader never own the same bank at once
  always_comb begin
    bank_st_nxt[0] = bank_st[0];
    bank_st_nxt[1] = bank_st[1];
    if (wr_acc) bank_st_nxt[wbank] = wr_last ? B_FULL : B_FILLING;
    if (mem_re) bank_st_nxt[rbank] = rd_last ? B_EMPTY : B_DRAINING;
  end

  // Handshakes and RAM strobes; read credit counts this cycle's pop so a
  // continuously ready consumer sees one bit per cycle
  always_comb begin
    wr_ready  = (bank_st[wbank] == B_EMPTY) || (bank_st[wbank] == B_FILLING);
    wr_acc    = wr_valid && wr_ready;
    wr_last   = wr_acc && (wcnt == LAST);
`ifdef PPBUF_STATUS_EN
    idx_bad   = {1'b0, wr_index} >= (AW+1)'(NCBPS);
`else
    idx_bad   = 1'b0;
`endif
    mem_we    = wr_acc && !idx_bad;
    mem_wbank = wbank;
    mem_waddr = wr_index;
    mem_wdata = wr_data;
    out_valid = (fifo_occ != 2'd0);
    out_data  = out_valid && fifo_mem[fifo_rp];
    pop       = out_valid && out_ready;
    credit    = fifo_occ + {1'b0, inflight} - {1'b0, pop};
    mem_re    = ((bank_st[rbank] == B_FULL) || (bank_st[rbank] == B_DRAINING)) &&
                (credit < 2'd2);
    mem_rbank = rbank;
    mem_raddr = rcnt;
    rd_last   = mem_re && (rcnt == LAST);
  end

  // Skid FIFO: RAM data lands one cycle after the read issue
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fifo_mem[0] <= 1'b0;
      fifo_mem[1] <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_wp     <= 1'b0;
      fifo_occ    <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_mem[fifo_wp] <= mem_q;
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      fifo_occ <= fifo_occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

`ifdef PPBUF_STATUS_EN
  // Drain counter and sticky index error flag
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blk_cnt <= 16'd0;
      idx_err <= 1'b0;
    end else begin
      if (rd_last) blk_cnt <= blk_cnt + 16'd1;
      if (wr_acc && idx_bad) idx_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ppbuf_ctrl.sv
// Self-checking bench for ppbuf_ctrl with a behavioural 2-bank RAM model.
module tb_ppbuf_ctrl;
  localparam int NCBPS = 192;
  localparam int AW    = 8;
  localparam int QN    = 8192;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_index = '0;
  logic          wr_data = 1'b0;
  logic          wr_ready, mem_we, mem_wbank, mem_wdata, mem_re, mem_rbank;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic          mem_q = 1'b0;
  logic          out_valid, out_data;
  logic          out_ready = 1'b0;
`ifdef PPBUF_STATUS_EN
  logic [15:0]   blk_cnt;
  logic          idx_err;
`endif

  ppbuf_ctrl #(.NCBPS(NCBPS), .AW(AW)) dut (
    .clk(clk), .resetN(resetN),
    .wr_valid(wr_valid), .wr_index(wr_index), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_we(mem_we), .mem_wbank(mem_wbank), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_rbank(mem_rbank), .mem_raddr(mem_raddr), .mem_q(mem_q),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef PPBUF_STATUS_EN
    , .blk_cnt(blk_cnt), .idx_err(idx_err)
`endif
  );

  always #5 clk = ~clk;

  logic ram [2][256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_wbank][mem_waddr] <= mem_wdata;
    if (mem_re) mem_q <= ram[mem_rbank][mem_raddr];
  end

  // Consumer-side monitor: capture popped bits, check hold during stalls
  logic got_arr [QN];
  int   got_wr = 0, stall_bad = 0, re_total = 0;
  logic prev_stall = 1'b0, prev_data = 1'b0;
  always @(posedge clk) begin
    if (!resetN) prev_stall <= 1'b0;
    else begin
      if (mem_re) re_total <= re_total + 1;
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad <= stall_bad + 1;
      if (out_valid && out_ready && got_wr < QN) begin
        got_arr[got_wr] <= out_data;
        got_wr <= got_wr + 1;
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
    end
  end

  logic rnd_mode = 1'b0, ready_hold = 1'b1;
  always begin
    @(posedge clk); #1;
    out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_hold;
  end

  logic exp_arr [QN];
  int exp_wr = 0, exp_rd = 0, got_rd = 0;
  int n_pass = 0, n_total = 0, wr_stalls = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int perm(input int k);
    return 12 * (k % 16) + k / 16;
  endfunction

  function automatic logic fbit(input int b, input int p);
    if (b < 0) return p[0];
    return ((p ^ (p >> 2) ^ (p >> 5) ^ b) & 1) != 0;
  endfunction

  task automatic resync();
    @(posedge clk); #1;
    got_rd = got_wr;
    exp_rd = exp_wr;
  endtask

  task automatic do_reset();
    wr_valid = 1'b0; wr_index = '0; wr_data = 1'b0;
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    resync();
  endtask

  task automatic write_one(input int idx, input logic d);
    int n;
    wr_valid = 1'b1; wr_index = AW'(idx); wr_data = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (wr_ready) break;
      wr_stalls++;
      n++;
      if (n > 3000) begin chk("wr_ready_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic write_block(input int b, input bit il);
    int p;
    for (int k = 0; k < NCBPS; k++) begin
      p = il ? perm(k) : k;
      write_one(p, fbit(b, p));
    end
    for (int q = 0; q < NCBPS; q++) begin
      exp_arr[exp_wr] = fbit(b, q);
      exp_wr++;
    end
  endtask

  task automatic check_stream(input string nm, input int budget);
    int cyc, n, bad;
    cyc = 0;
    n = exp_wr - exp_rd;
    while ((got_wr - got_rd) < n && cyc < budget) begin
      @(negedge clk); cyc++;
    end
    repeat (8) @(negedge clk);
    chk({nm, "_len"}, got_wr - got_rd, n);
    bad = 0;
    for (int i = 0; i < n; i++)
      if (got_rd + i >= got_wr || got_arr[got_rd + i] !== exp_arr[exp_rd + i]) bad++;
    chk({nm, "_bits"}, bad, 0);
    got_rd = got_wr;
    exp_rd = exp_wr;
  endtask

  typedef struct {
    logic          v;
    logic [AW-1:0] idx;
    logic          d;
    logic          exp_we;
    logic [AW-1:0] exp_waddr;
    logic          exp_wdata;
  } vec_t;
  vec_t vecs [6];

  initial begin
    int n;
    vecs[0] = '{1'b0, 8'd0,   1'b0, 1'b0, 8'd0,   1'b0};
    vecs[1] = '{1'b1, 8'd5,   1'b1, 1'b1, 8'd5,   1'b1};
    vecs[2] = '{1'b1, 8'd191, 1'b0, 1'b1, 8'd191, 1'b0};
    vecs[3] = '{1'b0, 8'd7,   1'b1, 1'b0, 8'd7,   1'b1};
    vecs[4] = '{1'b1, 8'd0,   1'b1, 1'b1, 8'd0,   1'b1};
    vecs[5] = '{1'b1, 8'd100, 1'b1, 1'b1, 8'd100, 1'b1};

    // Reset values
    #12;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk) resetN = 1'b1;
    resync();

    // Write-side pass-through vectors
    for (int i = 0; i < 6; i++) begin
      wr_valid = vecs[i].v; wr_index = vecs[i].idx; wr_data = vecs[i].d;
      @(negedge clk);
      chk("vec_wr_ready", wr_ready, 1);
      chk("vec_mem_we", mem_we, vecs[i].exp_we);
      chk("vec_mem_waddr", mem_waddr, vecs[i].exp_waddr);
      chk("vec_mem_wdata", mem_wdata, vecs[i].exp_wdata);
      chk("vec_mem_wbank", mem_wbank, 0);
      chk("vec_mem_re", mem_re, 0);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;

    // Single linear block, first-output latency
    ready_hold = 1'b1;
    do_reset();
    write_block(-1, 1'b0);
    @(negedge clk);
    chk("t1_first_re", mem_re, 1);
    chk("t1_first_rbank", mem_rbank, 0);
    chk("t1_ov_c1", out_valid, 0);
    @(negedge clk);
    chk("t1_ov_c2", out_valid, 0);
    @(negedge clk);
    chk("t1_ov_c3", out_valid, 1);
    chk("t1_first_bit", out_data, 0);
    check_stream("t1_stream", 1000);
    chk("t1_idle_re", mem_re, 0);
    chk("t1_idle_ov", out_valid, 0);
    chk("t1_idle_wr_ready", wr_ready, 1);

    // Three interleaved blocks back to back
    do_reset();
    wr_stalls = 0;
    for (int b = 0; b < 3; b++) write_block(b, 1'b1);
    check_stream("t2_stream", 2000);
    chk("t2_bubbles_le2", int'(wr_stalls <= 2), 1);

    // Both banks full with the consumer stalled
    ready_hold = 1'b0;
    do_reset();
    n = re_total;
    write_block(3, 1'b1);
    write_block(4, 1'b1);
    @(negedge clk);
    chk("t3_wr_ready_full", wr_ready, 0);
    repeat (4) @(negedge clk);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_out_data", out_data, exp_arr[exp_rd]);
    chk("t3_mem_re_stop", mem_re, 0);
    chk("t3_reads_issued", re_total - n, 2);
    chk("t3_wr_ready_still", wr_ready, 0);
    ready_hold = 1'b1;
    check_stream("t3_stream", 2000);
    chk("t3_stall_hold", stall_bad, 0);

    // Random consumer backpressure over ten blocks
    do_reset();
    rnd_mode = 1'b1;
    for (int b = 10; b < 20; b++) write_block(b, 1'b1);
    check_stream("t4_stream", 6000);
    rnd_mode = 1'b0;
    chk("t4_stall_hold", stall_bad, 0);

    // Reset at the 100th read of bank 0
    do_reset();
    write_block(30, 1'b0);
    n = 0;
    for (int c = 0; c < 1000 && n < 100; c++) begin
      @(negedge clk);
      if (mem_re) n++;
    end
    chk("t5_read_count", n, 100);
    resetN = 1'b0;
    #1;
    chk("t5_rst_wr_ready", wr_ready, 1);
    chk("t5_rst_mem_we", mem_we, 0);
    chk("t5_rst_mem_re", mem_re, 0);
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_out_data", out_data, 0);
    @(posedge clk); #1 resetN = 1'b1;
    resync();
    write_block(31, 1'b1);
    n = 0;
    while (!mem_re && n < 20) begin @(negedge clk); n++; end
    chk("t5_fresh_rbank", mem_rbank, 0);
    check_stream("t5_stream", 1000);

    // Out-of-range index
    do_reset();
    wr_valid = 1'b1; wr_index = 8'd200; wr_data = 1'b1;
    @(negedge clk);
    chk("t6_oor_wr_ready", wr_ready, 1);
`ifdef PPBUF_STATUS_EN
    chk("t6_oor_mem_we", mem_we, 0);
    chk("t6_idx_err_before", idx_err, 0);
    @(posedge clk); #1 wr_valid = 1'b0;
    @(negedge clk);
    chk("t6_idx_err_set", idx_err, 1);
    for (int b = 40; b < 44; b++) write_block(b, 1'b1);
    repeat (600) @(negedge clk);
    chk("t6_blk_cnt", blk_cnt, 4);
    chk("t6_idx_err_sticky", idx_err, 1);
`else
    chk("t6_oor_mem_we", mem_we, 1);
    @(posedge clk); #1 wr_valid = 1'b0;
`endif
    resync();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
